// File: rtl/ifu_pkg.sv
// Shared defaults and FSM state encoding for the instruction fetch unit.
package ifu_pkg;

    localparam int              IFU_PC_W     = 16;
    localparam int              IFU_INSTR_W  = 16;
    localparam logic [15:0]     IFU_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_SQUASH = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter: sync reset, load from redirect target, or +1 (load wins).
// pc_nxt exposes the value pc takes at the next edge so new requests can use it.
module ifu_pc_reg
    import ifu_pkg::*;
#(
    parameter int              PC_W     = IFU_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] load_val,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_nxt
);

    always_comb begin
        pc_nxt = pc;
        if (load)
            pc_nxt = load_val;
        else if (inc)
            pc_nxt = pc + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else
            pc <= pc_nxt;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues word reads, delivers each word with a one-cycle C_IRWrite,
// squashes fetches hit by a redirect. IFU_TIMEOUT_EN adds a sticky fetch-timeout error.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              PC_W     = IFU_PC_W,
    parameter int              INSTR_W  = IFU_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = IFU_RESET_PC
`ifdef IFU_TIMEOUT_EN
    ,
    parameter int              TIMEOUT_CYC = 15
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               C_FetchEn,
    input  logic               C_PCWrite,
    input  logic [PC_W-1:0]    D_PCNext,
    output logic [PC_W-1:0]    A_MemAddr,
    output logic               C_MemRead,
    input  logic [INSTR_W-1:0] D_MemRData,
    input  logic               C_MemValid,
    output logic [INSTR_W-1:0] D_MemData,
    output logic               C_IRWrite,
    output logic [PC_W-1:0]    D_PCOut,
    output logic               C_Busy,
    output logic               C_FetchErr
);

    ifu_state_t      state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic            accept;
    logic            launch;
    logic            timeout;
    logic            fetch_err;

    // A word is kept only if the fetch was not redirected before or during its response.
    assign accept = (state == ST_REQ) && C_MemValid && !C_PCWrite;

    ifu_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (C_PCWrite),
        .load_val (D_PCNext),
        .inc      (accept),
        .pc       (pc),
        .pc_nxt   (pc_nxt)
    );

`ifdef IFU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout   = (state != ST_IDLE) && !C_MemValid &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign fetch_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE || C_MemValid)
                wait_cnt <= '0;
            else if (!timeout)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    assign C_FetchErr = fetch_err;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!C_PCWrite && C_FetchEn && !fetch_err)
                    state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (timeout)
                    state_nxt = ST_IDLE;
                else if (C_MemValid)
                    state_nxt = C_FetchEn ? ST_REQ : ST_IDLE;
                else if (C_PCWrite)
                    state_nxt = ST_SQUASH;
            end
            ST_SQUASH: begin
                if (timeout)
                    state_nxt = ST_IDLE;
                else if (C_MemValid)
                    state_nxt = C_FetchEn ? ST_REQ : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        C_Busy    = (state != ST_IDLE);
        C_MemRead = (state != ST_IDLE);
    end

    // A new request starts from idle or right behind a response; its address is the PC being written.
    assign launch = (state_nxt == ST_REQ) && ((state == ST_IDLE) || C_MemValid);

    always_ff @(posedge clk) begin
        if (rst) begin
            A_MemAddr <= RESET_PC;
            C_IRWrite <= 1'b0;
            D_MemData <= '0;
            D_PCOut   <= '0;
        end else begin
            C_IRWrite <= accept;
            if (accept) begin
                D_MemData <= D_MemRData;
                D_PCOut   <= A_MemAddr;
            end
            if (launch)
                A_MemAddr <= pc_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of instruction_fetch_unit against a transaction-level model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        C_FetchEn, C_PCWrite, C_MemValid;
    logic [15:0] D_PCNext, D_MemRData;
    logic [15:0] A_MemAddr, D_MemData, D_PCOut;
    logic        C_MemRead, C_IRWrite, C_Busy, C_FetchErr;
    logic [15:0] hi_addr, hi_data, hi_pcout;
    logic        hi_read, hi_irw, hi_busy, hi_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [0:255];

    // Model: PC, one outstanding request (address, squashed?), last delivered word.
    logic [15:0] m_pc, m_addr, m_data, m_pcout;
    logic        m_req, m_squash, m_err, m_irw;
    int          m_cnt;

    always #5 clk = ~clk;

    instruction_fetch_unit u_dut (
        .clk(clk), .rst(rst), .C_FetchEn(C_FetchEn), .C_PCWrite(C_PCWrite),
        .D_PCNext(D_PCNext), .A_MemAddr(A_MemAddr), .C_MemRead(C_MemRead),
        .D_MemRData(D_MemRData), .C_MemValid(C_MemValid), .D_MemData(D_MemData),
        .C_IRWrite(C_IRWrite), .D_PCOut(D_PCOut), .C_Busy(C_Busy), .C_FetchErr(C_FetchErr)
    );

    instruction_fetch_unit #(.RESET_PC(16'hFFFF)) u_dut_hi (
        .clk(clk), .rst(rst), .C_FetchEn(C_FetchEn), .C_PCWrite(C_PCWrite),
        .D_PCNext(D_PCNext), .A_MemAddr(hi_addr), .C_MemRead(hi_read),
        .D_MemRData(D_MemRData), .C_MemValid(C_MemValid), .D_MemData(hi_data),
        .C_IRWrite(hi_irw), .D_PCOut(hi_pcout), .C_Busy(hi_busy), .C_FetchErr(hi_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("mem_read",  16'(C_MemRead),  16'(m_req));
        chk("busy",      16'(C_Busy),     16'(m_req));
        chk("mem_addr",  A_MemAddr,       m_addr);
        chk("ir_write",  16'(C_IRWrite),  16'(m_irw));
        chk("mem_data",  D_MemData,       m_data);
        chk("pc_out",    D_PCOut,         m_pcout);
        chk("fetch_err", 16'(C_FetchErr), 16'(m_err));
    endtask

    task automatic model_update(input logic fe, input logic pw, input logic [15:0] nxt,
                                input logic vld, input logic [15:0] rd);
        m_irw = 1'b0;
        if (!m_req) begin
            if (pw)
                m_pc = nxt;
            else if (fe && !m_err) begin
                m_req  = 1'b1;
                m_addr = m_pc;
                m_cnt  = 0;
            end
        end else if (vld) begin
            if (!m_squash && !pw) begin
                m_irw   = 1'b1;
                m_data  = rd;
                m_pcout = m_addr;
                m_pc    = m_pc + 16'd1;
            end
            if (pw)
                m_pc = nxt;
            m_squash = 1'b0;
            if (fe) begin
                m_addr = m_pc;
                m_cnt  = 0;
            end else
                m_req = 1'b0;
        end else begin
            if (pw) begin
                m_pc     = nxt;
                m_squash = 1'b1;
            end
`ifdef IFU_TIMEOUT_EN
            m_cnt++;
            if (m_cnt == 15) begin
                m_err    = 1'b1;
                m_req    = 1'b0;
                m_squash = 1'b0;
            end
`endif
        end
    endtask

    task automatic step(input logic fe, input logic pw, input logic [15:0] nxt, input logic vld);
        logic [15:0] rd;
        rd         = mem[m_addr[7:0]];
        C_FetchEn  = fe;
        C_PCWrite  = pw;
        D_PCNext   = nxt;
        C_MemValid = vld;
        D_MemRData = rd;
        model_update(fe, pw, nxt, vld, rd);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        C_FetchEn = 1'b1; C_PCWrite = 1'b0; D_PCNext = 16'h1234;
        C_MemValid = 1'b1; D_MemRData = 16'hDEAD;
        repeat (2) @(posedge clk);
        #1;
        m_pc = 16'h0000; m_addr = 16'h0000; m_data = 16'h0000; m_pcout = 16'h0000;
        m_req = 1'b0; m_squash = 1'b0; m_err = 1'b0; m_irw = 1'b0; m_cnt = 0;
        check_all();
        chk("hi_reset_addr", hi_addr, 16'hFFFF);
        chk("hi_reset_busy", 16'(hi_busy), 16'h0);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] nxt;
        logic [15:0] w0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h8B48; mem[1] = 16'h9BC9; mem[2] = 16'h0B41;

        // reset
        do_reset();

        // zero-wait, back-to-back
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("t2_data0", D_MemData, 16'h8B48); chk("t2_pc0", D_PCOut, 16'h0000);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("t2_data1", D_MemData, 16'h9BC9); chk("t2_pc1", D_PCOut, 16'h0001);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("t2_data2", D_MemData, 16'h0B41); chk("t2_pc2", D_PCOut, 16'h0002);
        chk("t2_irw2", 16'(C_IRWrite), 16'h1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t2_idle", 16'(C_Busy), 16'h0);

        // response three cycles late
        step(1'b1, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0, 1'b0);
            chk("t3_addr_stable", A_MemAddr, 16'h0004);
            chk("t3_read_stable", 16'(C_MemRead), 16'h1);
        end
        step(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t3_irw", 16'(C_IRWrite), 16'h1);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("t3_single_pulse", 16'(C_IRWrite), 16'h0);
        chk("t3_pc_adv", A_MemAddr, 16'h0005);
        step(1'b0, 1'b0, 16'h0, 1'b1);

        // redirect before response
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h0040, 1'b0);
        chk("t4_held_addr", A_MemAddr, 16'h0006);
        step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("t4_dropped", 16'(C_IRWrite), 16'h0);
        chk("t4_new_addr", A_MemAddr, 16'h0040);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        chk("t4_pc_out", D_PCOut, 16'h0040);

        // PC wrap on the FFFF-reset instance
        do_reset();
        w0 = mem[0];
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("t5_hi_addr", hi_addr, 16'hFFFF);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        chk("t5_hi_irw", 16'(hi_irw), 16'h1);
        chk("t5_hi_pcout", hi_pcout, 16'hFFFF);
        chk("t5_hi_data", hi_data, w0);
        chk("t5_hi_wrap", hi_addr, 16'h0000);
        step(1'b0, 1'b0, 16'h0, 1'b1);

        // memory never answers
        do_reset();
        step(1'b1, 1'b0, 16'h0, 1'b0);
`ifdef IFU_TIMEOUT_EN
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("t6_still_waiting", 16'(C_MemRead), 16'h1);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        chk("t6_err", 16'(C_FetchErr), 16'h1);
        chk("t6_read_dropped", 16'(C_MemRead), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0, 1'b1);
            chk("t6_fetch_ignored", 16'(C_MemRead), 16'h0);
        end
        do_reset();
        chk("t6_err_cleared", 16'(C_FetchErr), 16'h0);
`else
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        chk("t6_wait_forever", 16'(C_MemRead), 16'h1);
        chk("t6_no_err", 16'(C_FetchErr), 16'h0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                nxt = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255))
                                                   : 16'(16'hFFF0 + 16'($urandom_range(0, 15)));
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 7) == 0,
                     nxt,
                     m_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
